// File: rtl/oci_dct_pkg.sv
// Shared constants for the OCI debug-capture-trace scheduler.
package oci_dct_pkg;
    localparam int unsigned DATA_W = 30;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 4;

    localparam logic SRC_ITR = 1'b0;
    localparam logic SRC_DTR = 1'b1;

    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    typedef logic [DATA_W:0] tm_word_t;
endpackage

// File: rtl/first_nios1_system_cpu_oci_dct_fifo.sv
// Register FIFO holding {src, word} trace entries; count is a separate up/down counter.
module first_nios1_system_cpu_oci_dct_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 31,
    parameter int unsigned CntW  = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            for (int i = 0; i < Depth; i++) mem_d[i] = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/first_nios1_system_cpu_oci_dct_sched.sv
// DCT scheduler: round-robin merge of instruction/data trace into a FIFO drained to trace memory.
module first_nios1_system_cpu_oci_dct_sched
    import oci_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wrap_mode,
    input  logic              clear,
    input  logic              itr_valid,
    input  logic [DATA_W-1:0] itr_data,
    output logic              itr_ready,
    input  logic              dtr_valid,
    input  logic [DATA_W-1:0] dtr_data,
    output logic              dtr_ready,
    input  logic              tm_ready,
    output logic              tm_wr,
    output logic [ADDR_W-1:0] tm_addr,
    output logic [DATA_W:0]   tm_wdata,
    output logic [DATA_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              tm_wrapped,
    output logic              tm_stopped,
    output logic              stall_seen
);
    // rr_q = 1 means the data-trace source wins the next contested cycle.
    logic              rr_q, rr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;
    logic              stopped_q, stopped_d;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic              active;
    logic              open;
    logic              push;
    tm_word_t          push_word;
    tm_word_t          head;
    logic [CNT_W-1:0]  count;

    first_nios1_system_cpu_oci_dct_fifo #(
        .Depth (DEPTH),
        .Width (DATA_W + 1),
        .CntW  (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (clear),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (tm_wr),
        .rdata_o (head),
        .count_o (count)
    );

    // Reset and clear force handshakes low so no transfer happens on those cycles.
    always_comb begin
        active    = ~reset & ~clear;
        open      = active & enable & ~stopped_q & (count < DEPTH_CNT);
        itr_ready = open & itr_valid & (~dtr_valid | ~rr_q);
        dtr_ready = open & dtr_valid & (~itr_valid | rr_q);
        push      = itr_ready | dtr_ready;
        push_word = dtr_ready ? {SRC_DTR, dtr_data} : {SRC_ITR, itr_data};
        tm_wr     = active & (count != '0) & tm_ready & ~stopped_q;
    end

    always_comb begin
        rr_d      = rr_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        stopped_d = stopped_q;
        stall_d   = stall_q;
        buf_d     = buf_q;
        if (clear) begin
            rr_d      = 1'b0;
            addr_d    = '0;
            wrapped_d = 1'b0;
            stopped_d = 1'b0;
            stall_d   = 1'b0;
            buf_d     = '0;
        end else begin
            if (push) begin
                rr_d  = itr_ready;
                buf_d = itr_ready ? itr_data : dtr_data;
            end
            if (tm_wr) begin
                if (addr_q == ADDR_MAX) begin
                    if (wrap_mode) begin
                        addr_d    = '0;
                        wrapped_d = 1'b1;
                    end else begin
                        stopped_d = 1'b1;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            if ((itr_valid | dtr_valid) & enable & ~stopped_q & (count == DEPTH_CNT)) begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q      <= 1'b0;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
            stopped_q <= 1'b0;
            stall_q   <= 1'b0;
            buf_q     <= '0;
        end else begin
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
            stopped_q <= stopped_d;
            stall_q   <= stall_d;
            buf_q     <= buf_d;
        end
    end

    assign tm_addr    = addr_q;
    assign tm_wdata   = head;
    assign dct_buffer = buf_q;
    assign dct_count  = count;
    assign tm_wrapped = wrapped_q;
    assign tm_stopped = stopped_q;
    assign stall_seen = stall_q;
endmodule

// File: tb/tb_first_nios1_system_cpu_oci_dct_sched.sv
// Directed self-checking bench for the OCI DCT scheduler.
module tb_first_nios1_system_cpu_oci_dct_sched;
    logic        clk;
    logic        reset;
    logic        enable;
    logic        wrap_mode;
    logic        clear;
    logic        itr_valid;
    logic [29:0] itr_data;
    logic        itr_ready;
    logic        dtr_valid;
    logic [29:0] dtr_data;
    logic        dtr_ready;
    logic        tm_ready;
    logic        tm_wr;
    logic [6:0]  tm_addr;
    logic [30:0] tm_wdata;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        tm_wrapped;
    logic        tm_stopped;
    logic        stall_seen;

    int n_cmp = 0;
    int n_err = 0;

    int          wr_cnt = 0;
    logic [6:0]  wr_addr_log [1024];
    logic        wr_src_log  [1024];

    first_nios1_system_cpu_oci_dct_sched dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wrap_mode  (wrap_mode),
        .clear      (clear),
        .itr_valid  (itr_valid),
        .itr_data   (itr_data),
        .itr_ready  (itr_ready),
        .dtr_valid  (dtr_valid),
        .dtr_data   (dtr_data),
        .dtr_ready  (dtr_ready),
        .tm_ready   (tm_ready),
        .tm_wr      (tm_wr),
        .tm_addr    (tm_addr),
        .tm_wdata   (tm_wdata),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .tm_wrapped (tm_wrapped),
        .tm_stopped (tm_stopped),
        .stall_seen (stall_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trace-memory write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (tm_wr && wr_cnt < 1024) begin
            wr_addr_log[wr_cnt] = tm_addr;
            wr_src_log[wr_cnt]  = tm_wdata[30];
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        itr_valid = 1'b0;
        dtr_valid = 1'b0;
        itr_data  = '0;
        dtr_data  = '0;
        clear     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int acc;
    int base;
    int i_acc;
    int d_acc;

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        wrap_mode = 1'b1;
        tm_ready  = 1'b0;
        idle_inputs();
        tick();
        tick();
        #1;
        check("rst_tm_wr", tm_wr, 0);
        check("rst_addr", tm_addr, 0);
        check("rst_count", dct_count, 0);
        check("rst_buffer", dct_buffer, 0);
        check("rst_flags", {tm_wrapped, tm_stopped, stall_seen}, 0);
        check("rst_wdata", tm_wdata, 0);
        reset = 1'b0;

        // 1: single itr word, one-cycle latency to the trace memory.
        tick();
        enable = 1'b1; tm_ready = 1'b1; wrap_mode = 1'b1;
        itr_valid = 1'b1; itr_data = 30'h1234567;
        #1;
        check("t1_itr_ready", itr_ready, 1);
        check("t1_no_early_wr", tm_wr, 0);
        tick();
        itr_valid = 1'b0;
        #1;
        check("t1_tm_wr", tm_wr, 1);
        check("t1_tm_addr", tm_addr, 0);
        check("t1_tm_wdata", tm_wdata, {1'b0, 30'h1234567});
        check("t1_buffer", dct_buffer, 30'h1234567);
        tick();
        #1;
        check("t1_addr_after", tm_addr, 1);
        check("t1_count_after", dct_count, 0);

        // 2: contested round-robin.
        do_reset();
        enable = 1'b1; tm_ready = 1'b1;
        base = wr_cnt;
        for (int k = 0; k < 4; k++) begin
            itr_valid = 1'b1; itr_data = 30'h100 + 30'(k);
            dtr_valid = 1'b1; dtr_data = 30'h200 + 30'(k);
            #1;
            check("t2_itr_ready", itr_ready, (k % 2 == 0) ? 1 : 0);
            check("t2_dtr_ready", dtr_ready, (k % 2 == 1) ? 1 : 0);
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) tick();
        check("t2_nwr", wr_cnt - base, 4);
        for (int k = 0; k < 4; k++) check("t2_src", wr_src_log[base + k], (k % 2 == 1) ? 1 : 0);

        // 3: fill the FIFO, stall, then drain.
        do_reset();
        enable = 1'b1; tm_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            itr_valid = 1'b1; itr_data = 30'h300 + 30'(k);
            #1;
            if (itr_ready) acc++;
            tick();
        end
        #1;
        check("t3_accepted", acc, 8);
        check("t3_count_full", dct_count, 8);
        check("t3_ready_full", itr_ready, 0);
        check("t3_stall", stall_seen, 1);
        check("t3_buffer", dct_buffer, 30'h307);
        tick();
        itr_valid = 1'b0; tm_ready = 1'b1;
        base = wr_cnt;
        for (int k = 0; k < 10; k++) tick();
        check("t3_drained_wr", wr_cnt - base, 8);
        check("t3_count_empty", dct_count, 0);

        // 4: stop mode.
        do_reset();
        enable = 1'b1; tm_ready = 1'b1; wrap_mode = 1'b0;
        base = wr_cnt;
        acc = 0;
        for (int k = 0; k < 200 && acc < 130; k++) begin
            itr_valid = 1'b1; itr_data = 30'(acc);
            #1;
            if (itr_ready) acc++;
            tick();
        end
        #1;
        check("t4_accepted", acc, 129);
        check("t4_nwr", wr_cnt - base, 128);
        check("t4_first_addr", wr_addr_log[base], 0);
        check("t4_last_addr", wr_addr_log[base + 127], 127);
        check("t4_stopped", tm_stopped, 1);
        check("t4_addr_hold", tm_addr, 127);
        check("t4_ready_low", itr_ready, 0);
        check("t4_wr_low", tm_wr, 0);
        check("t4_retained", dct_count, 1);
        check("t4_wrapped", tm_wrapped, 0);

        // 5: wrap mode.
        do_reset();
        enable = 1'b1; tm_ready = 1'b1; wrap_mode = 1'b1;
        base = wr_cnt;
        acc = 0;
        for (int k = 0; k < 200 && acc < 130; k++) begin
            itr_valid = 1'b1; itr_data = 30'(acc);
            #1;
            if (itr_ready) acc++;
            tick();
        end
        itr_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #1;
        check("t5_accepted", acc, 130);
        check("t5_nwr", wr_cnt - base, 130);
        check("t5_w128_addr", wr_addr_log[base + 127], 127);
        check("t5_w129_addr", wr_addr_log[base + 128], 0);
        check("t5_wrapped", tm_wrapped, 1);
        check("t5_stopped", tm_stopped, 0);
        check("t5_addr_end", tm_addr, 2);

        // 6: clear with traffic in flight, then asynchronous reset mid-stream.
        tick();
        tm_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            itr_valid = 1'b1; itr_data = 30'h500 + 30'(k);
            tick();
        end
        #1;
        check("t6_count5", dct_count, 5);
        tick();
        tm_ready = 1'b1; itr_valid = 1'b1; dtr_valid = 1'b1; dtr_data = 30'h5ff;
        clear = 1'b1;
        tick();
        clear = 1'b0; itr_valid = 1'b0; dtr_valid = 1'b0; tm_ready = 1'b0;
        #1;
        check("t6_clr_count", dct_count, 0);
        check("t6_clr_addr", tm_addr, 0);
        check("t6_clr_flags", {tm_wrapped, tm_stopped, stall_seen}, 0);
        check("t6_clr_buffer", dct_buffer, 0);
        tick();
        tm_ready = 1'b1;
        i_acc = 0; d_acc = 0;
        for (int k = 0; k < 5; k++) begin
            itr_valid = 1'b1; itr_data = 30'h600 + 30'(k);
            dtr_valid = 1'b1; dtr_data = 30'h700 + 30'(k);
            #1;
            if (itr_ready) i_acc++;
            if (dtr_ready) d_acc++;
            tick();
        end
        check("t6_rr_after_clear", {i_acc[7:0], d_acc[7:0]}, {8'd3, 8'd2});
        #1;
        check("t6_pre_rst_addr", tm_addr, 4);
        reset = 1'b1;
        #1;
        check("t6_rst_ready", {itr_ready, dtr_ready}, 0);
        check("t6_rst_tm_wr", tm_wr, 0);
        check("t6_rst_addr", tm_addr, 0);
        check("t6_rst_count", dct_count, 0);
        check("t6_rst_buffer", dct_buffer, 0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
